// File: rtl/rotate_shift_engine_pkg.sv
// Shared types for the rotate/shift engine: opcodes and FSM states.
package rotate_shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ROR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for opcodes that move bits and may therefore need RUN cycles.
  function automatic logic is_move(input op_e op);
    return (op == OP_ROR) || (op == OP_ROL) || (op == OP_SLL) ||
           (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/rotate_shift_engine_if.sv
// Command/result bundle for the rotate/shift engine.
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; the master holds cmd_op/cmd_amt/data stable while
// cmd_valid is high, and cmd_ready never depends combinationally on cmd_valid.
interface rotate_shift_engine_if #(
  parameter int WIDTH = 100,
  parameter int AMT_W = $clog2(WIDTH + 1)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, data,
    input  cmd_ready, q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, data,
    output cmd_ready, q, busy, done
  );
endinterface

// File: rtl/rotate_shift_engine_shift_step.sv
// One combinational step: move q by k (0..STEP) positions per op.
module shift_step
  import rotate_shift_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int STEP  = 8,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_q,
  input  op_e              i_op,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_q
);

  // Rotates come from a doubled copy so wrapped bits fall out of the shift.
  logic [2*WIDTH-1:0] w_dbl_r;
  logic [2*WIDTH-1:0] w_dbl_l;

  assign w_dbl_r = {i_q, i_q} >> i_k;
  assign w_dbl_l = {i_q, i_q} << i_k;

  // Select the moved value; non-moving ops pass q through.
  always_comb begin
    o_q = i_q;
    case (i_op)
      OP_ROR:  o_q = w_dbl_r[WIDTH-1:0];
      OP_ROL:  o_q = w_dbl_l[2*WIDTH-1:WIDTH];
      OP_SLL:  o_q = i_q << i_k;
      OP_SRL:  o_q = i_q >> i_k;
      OP_SRA:  o_q = $signed(i_q) >>> i_k;
      default: o_q = i_q;
    endcase
  end

endmodule

// File: rtl/rotate_shift_engine.sv
// Multi-mode shift/rotate register; large amounts run STEP bits per cycle.
module rotate_shift_engine
  import rotate_shift_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int STEP  = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  rotate_shift_engine_if.slave  bus,
  output state_e                dbg_state
);

  localparam int KW = $clog2(STEP + 1);

  state_e           r_state;
  op_e              r_op;
  logic [AMT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic             r_done;

  op_e              w_cmd_op;
  logic [KW-1:0]    w_k;
  logic [WIDTH-1:0] w_q_next;

  assign w_cmd_op = op_e'(bus.cmd_op);

  // This cycle's move: the remaining count, capped at STEP.
  assign w_k = (r_rem < AMT_W'(STEP)) ? KW'(r_rem) : KW'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .i_q  (r_q),
    .i_op (r_op),
    .i_k  (w_k),
    .o_q  (w_q_next)
  );

  // Command FSM: single-cycle ops finish in IDLE, moves step through RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_rem   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (w_cmd_op == OP_LOAD) begin
              r_q    <= bus.data;
              r_done <= 1'b1;
            end else if (is_move(w_cmd_op) && (bus.cmd_amt != '0)) begin
              r_op    <= w_cmd_op;
              r_rem   <= bus.cmd_amt;
              r_state <= ST_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_q   <= w_q_next;
          r_rem <= r_rem - AMT_W'(w_k);
          if (r_rem == AMT_W'(w_k)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.q         = r_q;
  assign bus.done      = r_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_rotate_shift_engine.sv
// Bench for rotate_shift_engine: directed table, hand sequences, random ops.
module tb_rotate_shift_engine;
  import rotate_shift_pkg::*;

  localparam int W  = 100;
  localparam int S  = 8;
  localparam int AW = $clog2(W + 1);

  logic   clk = 1'b0;
  logic   resetn;
  state_e dbg_state;

  rotate_shift_engine_if #(.WIDTH(W), .AMT_W(AW)) bus();

  rotate_shift_engine #(.WIDTH(W), .STEP(S), .AMT_W(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;

  typedef struct {
    logic [2:0]   op;
    int           amt;
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vt[18];

  task automatic chk_v(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: whole-amount result straight from the operation's definition.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input int amt,
                                          input logic [W-1:0] q, input logic [W-1:0] d);
    logic signed [W-1:0] s;
    int r;
    s = q;
    r = amt % W;
    case (op)
      3'b001: return d;
      3'b010: return (r == 0) ? q : ((q >> r) | (q << (W - r)));
      3'b011: return (r == 0) ? q : ((q << r) | (q >> (W - r)));
      3'b100: return (amt >= W) ? '0 : (q << amt);
      3'b101: return (amt >= W) ? '0 : (q >> amt);
      3'b110: return (amt >= W) ? {W{q[W-1]}} : W'(s >>> amt);
      default: return q;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int amt);
    if (op >= 3'b010 && op <= 3'b110 && amt > 0) return (amt + S - 1) / S;
    return 0;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Driver: issue one command, wait for done, check latency and result.
  task automatic run_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] d,
                         input bit junk, output int lat, output logic [W-1:0] q_out);
    logic [W-1:0] e;
    bit got_done;
    e = ref_op(op, amt, model_q, d);
    model_q = e;
    exp_q.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = AW'(amt);
    bus.data      = d;
    chk_i("ready_idle", int'(bus.cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
        bus.cmd_valid = 1'b0;
        break;
      end
      chk_i("busy_not_ready", int'({bus.busy, bus.cmd_ready}), 2);
      if (junk) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_amt   = AW'($urandom_range(0, 127));
        bus.data      = rand_data();
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk_i("done_seen", int'(got_done), 1);
    chk_i("latency", lat, ref_lat(op, amt));
    chk_v("q_result", bus.q, exp_q.pop_front());
    chk_i("busy_after", int'(bus.busy), 0);
    q_out = bus.q;
  endtask

  // done must drop after exactly one cycle when nothing new is issued.
  task automatic settle();
    @(negedge clk);
    chk_i("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] qo, b99, ones, x1, d;

    b99 = '0;
    b99[W-1] = 1'b1;
    ones = '1;
    x1 = 100'h1234_5678_9ABC_DEF0_1234_5678_9;

    vt[0]  = '{3'b001, 0,   100'd1,     100'd1,     0};
    vt[1]  = '{3'b011, 1,   '0,         100'd2,     1};
    vt[2]  = '{3'b010, 1,   '0,         100'd1,     1};
    vt[3]  = '{3'b001, 0,   b99 | 100'd1, b99 | 100'd1, 0};
    vt[4]  = '{3'b010, 100, '0,         b99 | 100'd1, 13};
    vt[5]  = '{3'b001, 5,   b99,        b99,        0};
    vt[6]  = '{3'b110, 127, '0,         ones,       16};
    vt[7]  = '{3'b001, 0,   b99,        b99,        0};
    vt[8]  = '{3'b101, 127, '0,         '0,         16};
    vt[9]  = '{3'b001, 0,   x1,         x1,         0};
    vt[10] = '{3'b011, 0,   '0,         x1,         0};
    vt[11] = '{3'b111, 5,   '0,         x1,         0};
    vt[12] = '{3'b000, 9,   '0,         x1,         0};
    vt[13] = '{3'b100, 3,   '0,         x1 << 3,    1};
    vt[14] = '{3'b011, 100, '0,         x1 << 3,    13};
    vt[15] = '{3'b001, 0,   ones,       ones,       0};
    vt[16] = '{3'b110, 100, '0,         ones,       13};
    vt[17] = '{3'b100, 100, '0,         '0,         13};

    // Reset
    resetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'b000;
    bus.cmd_amt = '0;
    bus.data = '0;
    model_q = '0;
    #12;
    chk_v("reset_q", bus.q, '0);
    chk_i("reset_busy", int'(bus.busy), 0);
    chk_i("reset_done", int'(bus.done), 0);
    chk_i("reset_ready", int'(bus.cmd_ready), 1);
    chk_i("reset_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      run_cmd(vt[i].op, vt[i].amt, vt[i].d, 1'b0, lat, qo);
      chk_v("tbl_q", qo, vt[i].exp);
      chk_i("tbl_lat", lat, vt[i].lat);
      settle();
    end

    // Junk commands while busy, then a LOAD accepted in the done cycle
    run_cmd(3'b001, 0, x1, 1'b0, lat, qo);
    settle();
    run_cmd(3'b100, 20, '0, 1'b1, lat, qo);
    d = rand_data();
    model_q = d;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b001;
    bus.cmd_amt = '0;
    bus.data = d;
    chk_i("ready_in_done", int'(bus.cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk_i("done_b2b", int'(bus.done), 1);
    chk_v("load_in_done_q", bus.q, d);
    settle();

    // Randomised commands against the reference model
    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 127), rand_data(),
              1'($urandom_range(0, 1)), lat, qo);
      settle();
    end

    // Reset in the middle of a long shift
    run_cmd(3'b001, 0, ones, 1'b0, lat, qo);
    settle();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b100;
    bus.cmd_amt = AW'(60);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_i("busy_before_reset", int'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk_v("midreset_q", bus.q, '0);
    chk_i("midreset_busy", int'(bus.busy), 0);
    chk_i("midreset_done", int'(bus.done), 0);
    chk_i("midreset_ready", int'(bus.cmd_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk_i("no_done_in_reset", int'(bus.done), 0);
    end
    resetn = 1'b1;
    d = rand_data();
    model_q = d;
    exp_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b001;
    bus.data = d;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk_i("post_reset_done", int'(bus.done), 1);
    chk_v("post_reset_load", bus.q, d);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
